snake_body_ctrl: RTL and testbench

//  Snake movement/body engine directly upstream of the pixel-frame generator.

---
 rtl/snake_pkg.sv | 49 ++++
 rtl/snake_body_fifo.sv | 59 +++++
 rtl/snake_body_ctrl.sv | 166 ++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine and the pixel-frame generator.
// Position encoding: pos[7:4] = row 0..7, pos[3:0] = col 0..15.
package snake_pkg;

   typedef logic [7:0] pos_t;
   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   localparam int ROWS  = 8;
   localparam int COLS  = 16;
   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);

   // Initial snake, index 0 = tail, index 2 = head.
   localparam logic [2:0][7:0] INIT_BODY = {8'h20, 8'h10, 8'h00};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_CHECK,
      ST_COMMIT,
      ST_DEAD
   } state_t;

   // Up/down and left/right differ only in bit 0, so the reverse is a single flip.
   function automatic dir_t reverse_dir(input dir_t d);
      return d ^ 2'b01;
   endfunction

   // One cell in direction d; row and col wrap by natural overflow of their fields.
   function automatic pos_t next_cell(input pos_t p, input dir_t d);
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      row = p[4 +: ROW_W];
      col = p[0 +: COL_W];
      case (d)
         DIR_UP:    row = row - ROW_W'(1);
         DIR_DOWN:  row = row + ROW_W'(1);
         DIR_LEFT:  col = col - COL_W'(1);
         default:   col = col + COL_W'(1);
      endcase
      return {1'b0, row, col};
   endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of body cells: tail at tail_ptr, head at head_ptr.
// Pushing and popping in the same cycle keeps len and slides the window.
module snake_body_fifo
   import snake_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int PTR_W   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             push,
   input  logic             pop,
   input  pos_t             push_data,
   input  logic [PTR_W-1:0] rd_idx,
   output pos_t             head_data,
   output pos_t             tail_data,
   output pos_t             rd_data,
   output logic [PTR_W:0]   len
);

   pos_t             mem [MAX_LEN];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign rd_ptr    = tail_ptr + rd_idx;
   assign head_data = mem[head_ptr];
   assign tail_data = mem[tail_ptr];
   assign rd_data   = mem[rd_ptr];

   // Buffer storage and pointers; load restores the three-cell start snake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) mem[i] <= '0;
         mem[0]   <= INIT_BODY[0];
         mem[1]   <= INIT_BODY[1];
         mem[2]   <= INIT_BODY[2];
         head_ptr <= PTR_W'(2);
         tail_ptr <= '0;
         len      <= (PTR_W+1)'(3);
      end else if (load) begin
         mem[0]   <= INIT_BODY[0];
         mem[1]   <= INIT_BODY[1];
         mem[2]   <= INIT_BODY[2];
         head_ptr <= PTR_W'(2);
         tail_ptr <= '0;
         len      <= (PTR_W+1)'(3);
      end else begin
         if (push) begin
            mem[head_ptr + PTR_W'(1)] <= push_data;
            head_ptr                  <= head_ptr + PTR_W'(1);
         end
         if (pop) tail_ptr <= tail_ptr + PTR_W'(1);
         len <= len + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake movement/body engine feeding the pixel-frame generator.
// Optional build macro SELF_COLLISION_EN: scan the body for self-collision
// before each move and stop the game on a hit.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | waiting for step_tick
// CHECK  | scanning body one entry per cycle against the next head
// COMMIT | move registered, genreq high for this cycle
// DEAD   | self-collision seen, frozen until start
module snake_body_ctrl
   import snake_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int PTR_W   = $clog2(MAX_LEN)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       step_tick,
   input  logic [1:0] dir_in,
   input  logic [7:0] food_pos,
   output logic [7:0] head_pos,
   output logic [7:0] tail_pos,
   output logic       tail_clr,
   output logic       genreq,
   output logic       pix_init,
   output logic       food_eaten,
   output logic       game_over
);

   state_t           state_q, state_d;
   dir_t             dir_q, move_dir;
   pos_t             head_data, tail_data, nh_run, nh;
   logic [PTR_W:0]   len;
   logic [PTR_W-1:0] rd_idx;
   logic             accept, commit, grow, push, pop;

   assign move_dir = (dir_in == reverse_dir(dir_q)) ? dir_q : dir_in;
   assign nh_run   = next_cell(head_data, move_dir);
   assign accept   = (state_q == ST_RUN) && step_tick && !start;

`ifdef SELF_COLLISION_EN
   pos_t             nh_q, rd_data;
   logic [PTR_W-1:0] idx_q;
   logic             scan_hit, scan_last, game_over_q;

   assign nh        = (state_q == ST_CHECK) ? nh_q : nh_run;
   // The tail entry is being retired unless this move grows the snake.
   assign scan_hit  = (rd_data == nh_q) && !((idx_q == '0) && !grow);
   assign scan_last = ({1'b0, idx_q} == len - (PTR_W+1)'(1));
   assign commit    = (state_q == ST_CHECK) && scan_last && !scan_hit;
   assign rd_idx    = idx_q;
   assign game_over = game_over_q;
`else
   assign nh        = nh_run;
   assign commit    = accept;
   assign rd_idx    = '0;
   assign game_over = 1'b0;
`endif

   assign grow = (nh == food_pos) && (len < (PTR_W+1)'(MAX_LEN));
   assign push = commit && !start;
   assign pop  = push && !grow;

   snake_body_fifo #(.MAX_LEN(MAX_LEN), .PTR_W(PTR_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (start),
      .push      (push),
      .pop       (pop),
      .push_data (nh),
      .rd_idx    (rd_idx),
      .head_data (head_data),
      .tail_data (tail_data),
`ifdef SELF_COLLISION_EN
      .rd_data   (rd_data),
`else
      .rd_data   (),
`endif
      .len       (len)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; start overrides everything, including a same-cycle step.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
`ifdef SELF_COLLISION_EN
            ST_RUN:    if (step_tick) state_d = ST_CHECK;
            ST_CHECK:  if (scan_hit) state_d = ST_DEAD;
                       else if (scan_last) state_d = ST_COMMIT;
`else
            ST_RUN:    if (step_tick) state_d = ST_COMMIT;
            ST_CHECK:  state_d = ST_COMMIT;
`endif
            ST_COMMIT: state_d = ST_RUN;
            ST_DEAD:   state_d = ST_DEAD;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

`ifdef SELF_COLLISION_EN
   // Capture the candidate head at step time and walk the scan index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nh_q        <= '0;
         idx_q       <= '0;
         game_over_q <= 1'b0;
      end else begin
         if (accept) begin
            nh_q  <= nh_run;
            idx_q <= '0;
         end else if (state_q == ST_CHECK) begin
            idx_q <= idx_q + PTR_W'(1);
         end
         if (start) game_over_q <= 1'b0;
         else if ((state_q == ST_CHECK) && scan_hit) game_over_q <= 1'b1;
      end
   end
`endif

   // Direction latch and registered move outputs; pulses default low each cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q      <= DIR_DOWN;
         head_pos   <= INIT_BODY[2];
         tail_pos   <= INIT_BODY[0];
         tail_clr   <= 1'b0;
         genreq     <= 1'b0;
         pix_init   <= 1'b0;
         food_eaten <= 1'b0;
      end else begin
         genreq     <= 1'b0;
         pix_init   <= 1'b0;
         food_eaten <= 1'b0;
         if (start) begin
            dir_q    <= DIR_DOWN;
            head_pos <= INIT_BODY[2];
            tail_pos <= INIT_BODY[0];
            tail_clr <= 1'b0;
            pix_init <= 1'b1;
         end else begin
            if (accept) dir_q <= move_dir;
            if (commit) begin
               head_pos   <= nh;
               tail_clr   <= !grow;
               food_eaten <= (nh == food_pos);
               genreq     <= 1'b1;
               if (!grow) tail_pos <= tail_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl; builds with or without SELF_COLLISION_EN.
module tb_snake_body_ctrl;

`ifdef SELF_COLLISION_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       step_tick = 1'b0;
   logic [1:0] dir_in = 2'd1;
   logic [7:0] food_pos = 8'h77;
   logic [7:0] head_pos, tail_pos;
   logic       tail_clr, genreq, pix_init, food_eaten, game_over;

   int vec  = 0;
   int errs = 0;
   int blen = 3;

   logic [1:0] t_dir  [12] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
   logic [7:0] t_head [12] = '{8'h5F, 8'h4F, 8'h3F, 8'h2F, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h00, 8'h10};
   logic [7:0] t_tail [12] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h5F, 8'h4F, 8'h3F, 8'h2F, 8'h20, 8'h30, 8'h40, 8'h50};

   snake_body_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .step_tick  (step_tick),
      .dir_in     (dir_in),
      .food_pos   (food_pos),
      .head_pos   (head_pos),
      .tail_pos   (tail_pos),
      .tail_clr   (tail_clr),
      .genreq     (genreq),
      .pix_init   (pix_init),
      .food_eaten (food_eaten),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic no_genreq(input int cycles, input string tag);
      logic seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (genreq === 1'b1) seen = 1'b1;
      end
      chk(tag, seen, 0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("start_pix_init", pix_init, 1);
      chk("start_head", head_pos, 8'h20);
      chk("start_tail_clr", tail_clr, 0);
      chk("start_game_over", game_over, 0);
      @(negedge clk);
      chk("pix_init_pulse", pix_init, 0);
      blen = 3;
   endtask

   task automatic pulse_step(input logic [1:0] d, input logic [7:0] f);
      @(negedge clk);
      dir_in    = d;
      food_pos  = f;
      step_tick = 1'b1;
      @(posedge clk);
      #1 step_tick = 1'b0;
   endtask

   task automatic do_step(input logic [1:0] d, input logic [7:0] f, input logic [7:0] eh,
                          input logic [7:0] et, input logic ec, input logic efe);
      int lat;
      int exp_lat;
      exp_lat = SC ? 1 + blen : 1;
      pulse_step(d, f);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (genreq !== 1'b1 && lat < 60);
      chk("genreq_latency", lat, exp_lat);
      chk("head_pos", head_pos, eh);
      chk("tail_clr", tail_clr, ec);
      chk("food_eaten", food_eaten, efe);
      if (ec) chk("tail_pos", tail_pos, et);
      @(negedge clk);
      chk("genreq_one_cycle", genreq, 0);
      if (!ec) blen++;
   endtask

   initial begin
      int cnt;
      int dbl;
      logic prev;

      // reset values while held, then quiet idle
      repeat (2) @(negedge clk);
      chk("rst_head", head_pos, 8'h20);
      chk("rst_tail", tail_pos, 8'h00);
      chk("rst_tail_clr", tail_clr, 0);
      chk("rst_genreq", genreq, 0);
      chk("rst_pix_init", pix_init, 0);
      chk("rst_food_eaten", food_eaten, 0);
      chk("rst_game_over", game_over, 0);
      rst_n = 1'b1;
      no_genreq(20, "idle_no_genreq");
      pulse_step(2'd1, 8'h77);
      no_genreq(10, "idle_step_dropped");
      chk("idle_head", head_pos, 8'h20);

      // plain move, growth, and tail retire after growth
      pulse_start();
      do_step(2'd1, 8'h77, 8'h30, 8'h00, 1'b1, 1'b0);
      do_step(2'd1, 8'h40, 8'h40, 8'h00, 1'b0, 1'b1);
      chk("len_after_food", dut.u_fifo.len, 4);
      do_step(2'd1, 8'h77, 8'h50, 8'h10, 1'b1, 1'b0);

      // wrap in all directions and reverse-request rejection
      for (int i = 0; i < 12; i++) do_step(t_dir[i], 8'h77, t_head[i], t_tail[i], 1'b1, 1'b0);

      // step_tick held high: one genreq per move, extras dropped
      cnt  = 0;
      dbl  = 0;
      prev = 1'b0;
      @(negedge clk);
      dir_in    = 2'd1;
      step_tick = 1'b1;
      repeat (SC ? 12 : 8) begin
         @(negedge clk);
         if (genreq === 1'b1) cnt++;
         if (genreq === 1'b1 && prev) dbl++;
         prev = genreq;
      end
      step_tick = 1'b0;
      chk("held_genreq_count", cnt, SC ? 2 : 4);
      chk("held_back_to_back", dbl, 0);
      chk("held_head", head_pos, SC ? 8'h30 : 8'h50);
      chk("held_tail", tail_pos, SC ? 8'h70 : 8'h10);
      no_genreq(10, "held_no_queued_move");

      // start and step together: load only
      @(negedge clk);
      start     = 1'b1;
      step_tick = 1'b1;
      dir_in    = 2'd1;
      @(posedge clk);
      #1 start = 1'b0;
      step_tick = 1'b0;
      @(negedge clk);
      chk("start_step_pix_init", pix_init, 1);
      chk("start_step_head", head_pos, 8'h20);
      no_genreq(10, "start_step_no_move");
      blen = 3;

      // grow to len 5, then U-turn back onto the body
      do_step(2'd1, 8'h30, 8'h30, 8'h00, 1'b0, 1'b1);
      do_step(2'd1, 8'h40, 8'h40, 8'h00, 1'b0, 1'b1);
      do_step(2'd3, 8'h77, 8'h41, 8'h00, 1'b1, 1'b0);
      do_step(2'd0, 8'h77, 8'h31, 8'h10, 1'b1, 1'b0);
`ifdef SELF_COLLISION_EN
      pulse_step(2'd2, 8'h77);
      no_genreq(20, "collide_no_genreq");
      chk("collide_game_over", game_over, 1);
      chk("collide_head_held", head_pos, 8'h31);
      pulse_step(2'd2, 8'h77);
      no_genreq(20, "dead_no_genreq");
      chk("dead_game_over", game_over, 1);
`else
      do_step(2'd2, 8'h77, 8'h30, 8'h20, 1'b1, 1'b0);
      chk("pass_through_game_over", game_over, 0);
`endif

      // moving onto the cell retired this move is not a collision
      pulse_start();
      do_step(2'd1, 8'h30, 8'h30, 8'h00, 1'b0, 1'b1);
      do_step(2'd3, 8'h77, 8'h31, 8'h00, 1'b1, 1'b0);
      do_step(2'd0, 8'h77, 8'h21, 8'h10, 1'b1, 1'b0);
      do_step(2'd2, 8'h77, 8'h20, 8'h20, 1'b1, 1'b0);
      chk("retired_cell_game_over", game_over, 0);

      // reset in the middle of a move
      pulse_step(2'd1, 8'h77);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_genreq", genreq, 0);
      chk("midrst_head", head_pos, 8'h20);
      chk("midrst_tail_clr", tail_clr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      no_genreq(20, "midrst_no_pending");

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
